// File: rtl/instr_fetch_queue.sv
// ============================================================================
// instr_fetch_queue : circular buffer between fetch and the ID pipeline register
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int EXC_W  = 8,
  parameter int PRED_W = 34
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     IF_Valid,
  input  logic [31:0]              IF_Instr,
  input  logic [31:0]              IF_PC,
  input  logic [EXC_W-1:0]         IF_ExceptType,
  input  logic [PRED_W-1:0]        IF_PResult,
  output logic                     Q_Full,
  input  logic                     ID_Wr,
  input  logic                     ID_Flush,
  output logic                     Q_Valid,
  output logic [31:0]              Q_Instr,
  output logic [31:0]              Q_PC,
  output logic [EXC_W-1:0]         Q_ExceptType,
  output logic [PRED_W-1:0]        Q_PResult,
  output logic [$clog2(DEPTH):0]   Q_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]       instr_mem [DEPTH];
  logic [31:0]       pc_mem    [DEPTH];
  logic [EXC_W-1:0]  exc_mem   [DEPTH];
  logic [PRED_W-1:0] pred_mem  [DEPTH];

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;

  logic push;
  logic pop;

  assign Q_Full  = (cnt == FULL_CNT);
  assign Q_Valid = (cnt != '0);
  assign Q_Count = cnt;

  // Full rejects a push even when a pop happens in the same cycle (no bypass).
  assign push = IF_Valid && !Q_Full && !ID_Flush;
  assign pop  = ID_Wr && Q_Valid && !ID_Flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (ID_Flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is intentionally unreset; stale entries are hidden by Q_Valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wp] <= IF_Instr;
      pc_mem[wp]    <= IF_PC;
      exc_mem[wp]   <= IF_ExceptType;
      pred_mem[wp]  <= IF_PResult;
    end
  end

  always_comb begin
    Q_Instr      = '0;
    Q_PC         = '0;
    Q_ExceptType = '0;
    Q_PResult    = '0;
    if (Q_Valid) begin
      Q_Instr      = instr_mem[rp];
      Q_PC         = pc_mem[rp];
      Q_ExceptType = exc_mem[rp];
      Q_PResult    = pred_mem[rp];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// tb_instr_fetch_queue : directed self-checking bench for instr_fetch_queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        IF_Valid;
  logic [31:0] IF_Instr;
  logic [31:0] IF_PC;
  logic [7:0]  IF_ExceptType;
  logic [33:0] IF_PResult;
  logic        Q_Full;
  logic        ID_Wr;
  logic        ID_Flush;
  logic        Q_Valid;
  logic [31:0] Q_Instr;
  logic [31:0] Q_PC;
  logic [7:0]  Q_ExceptType;
  logic [33:0] Q_PResult;
  logic [2:0]  Q_Count;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .EXC_W(8), .PRED_W(34)) dut (
    .clk(clk), .resetn(resetn),
    .IF_Valid(IF_Valid), .IF_Instr(IF_Instr), .IF_PC(IF_PC),
    .IF_ExceptType(IF_ExceptType), .IF_PResult(IF_PResult),
    .Q_Full(Q_Full), .ID_Wr(ID_Wr), .ID_Flush(ID_Flush),
    .Q_Valid(Q_Valid), .Q_Instr(Q_Instr), .Q_PC(Q_PC),
    .Q_ExceptType(Q_ExceptType), .Q_PResult(Q_PResult), .Q_Count(Q_Count)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return ~pc;
  endfunction

  function automatic logic [33:0] pred_of(input logic [31:0] pc);
    return {2'b10, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic wr, input logic fl);
    IF_Valid      = v;
    IF_PC         = pc;
    IF_Instr      = instr_of(pc);
    IF_ExceptType = 8'h00;
    IF_PResult    = pred_of(pc);
    ID_Wr         = wr;
    ID_Flush      = fl;
  endtask

  initial begin
    resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #3;
    chk("rst_valid", 64'(Q_Valid), 64'd0);
    chk("rst_count", 64'(Q_Count), 64'd0);
    chk("rst_full",  64'(Q_Full),  64'd0);
    chk("rst_pc",    64'(Q_PC),    64'd0);
    chk("rst_instr", 64'(Q_Instr), 64'd0);
    step();
    resetn = 1'b1;

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
      step();
      chk("fill_count", 64'(Q_Count), 64'(i + 1));
    end
    chk("fill_full", 64'(Q_Full), 64'd1);
    chk("fill_head", 64'(Q_PC), 64'h1000);
    chk("fill_instr", 64'(Q_Instr), 64'(instr_of(32'h1000)));

    // Push to full queue rejected
    drive(1'b1, 32'h1010, 1'b0, 1'b0);
    step();
    chk("rej_count", 64'(Q_Count), 64'd4);
    chk("rej_head",  64'(Q_PC), 64'h1000);

    // Full with simultaneous pop: push still rejected
    drive(1'b1, 32'h1010, 1'b1, 1'b0);
    step();
    chk("fullpop_head",  64'(Q_PC), 64'h1004);
    chk("fullpop_count", 64'(Q_Count), 64'd3);
    chk("fullpop_full",  64'(Q_Full), 64'd0);
    drive(1'b1, 32'h1010, 1'b0, 1'b0);
    step();
    chk("retry_count", 64'(Q_Count), 64'd4);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", 64'(Q_PC), 64'h1004 + 64'(4 * i));
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      step();
    end
    chk("drain_count", 64'(Q_Count), 64'd0);
    chk("drain_valid", 64'(Q_Valid), 64'd0);

    // Steady state push+pop with pointer wrap
    drive(1'b1, 32'h3000, 1'b0, 1'b0);
    step();
    chk("ss_prime", 64'(Q_PC), 64'h3000);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'h3004 + 32'(4 * k), 1'b1, 1'b0);
      step();
      chk("ss_head",  64'(Q_PC), 64'h3004 + 64'(4 * k));
      chk("ss_count", 64'(Q_Count), 64'd1);
    end
    chk("ss_pred", 64'(Q_PResult), 64'(pred_of(32'h3050)));

    // Build 3 entries, then flush with a concurrent push
    drive(1'b1, 32'h3100, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h3104, 1'b0, 1'b0);
    step();
    chk("pre_flush_count", 64'(Q_Count), 64'd3);
    drive(1'b1, 32'h2000, 1'b1, 1'b1);
    step();
    chk("flush_valid", 64'(Q_Valid), 64'd0);
    chk("flush_count", 64'(Q_Count), 64'd0);
    chk("flush_pc",    64'(Q_PC), 64'd0);
    drive(1'b1, 32'hBFC00380, 1'b0, 1'b0);
    step();
    chk("redir_head",  64'(Q_PC), 64'hBFC00380);
    chk("redir_count", 64'(Q_Count), 64'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk("redir_pop", 64'(Q_Count), 64'd0);

    // ID_Wr on empty queue: bubble, stale storage masked
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk("empty_valid", 64'(Q_Valid), 64'd0);
    chk("empty_count", 64'(Q_Count), 64'd0);
    chk("empty_instr", 64'(Q_Instr), 64'd0);
    chk("empty_pc",    64'(Q_PC), 64'd0);
    chk("empty_exc",   64'(Q_ExceptType), 64'd0);
    chk("empty_pred",  64'(Q_PResult), 64'd0);

    // Exception entry passes through untouched
    drive(1'b1, 32'h4000, 1'b0, 1'b0);
    IF_ExceptType = 8'h04;
    step();
    chk("exc_bits",  64'(Q_ExceptType), 64'h04);
    chk("exc_pc",    64'(Q_PC), 64'h4000);
    chk("exc_instr", 64'(Q_Instr), 64'(instr_of(32'h4000)));
    chk("exc_pred",  64'(Q_PResult), 64'(pred_of(32'h4000)));
    drive(1'b1, 32'h4004, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("two_count", 64'(Q_Count), 64'd2);

    // Asynchronous reset mid-cycle
    #2;
    resetn = 1'b0;
    #1;
    chk("async_valid", 64'(Q_Valid), 64'd0);
    chk("async_count", 64'(Q_Count), 64'd0);
    chk("async_pc",    64'(Q_PC), 64'd0);
    step();
    resetn = 1'b1;
    step();
    chk("post_rst_count", 64'(Q_Count), 64'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch queue between the fetch stage and the ID pipeline register. Decouples instruction-cache return timing from ID stalls by buffering up to DEPTH fetched instructions with their PC, exception vector and branch-prediction record. The head entry drives the IF-side inputs of the ID register directly. ID_Flush, on a redirect or exception, empties the queue in one cycle.

## Interface
- DEPTH, 4: number of entries; must be a power of two and at least 2.
- EXC_W, 8: width of the fetch exception vector.
- PRED_W, 34: width of the packed prediction record (target, taken, type bits), carried opaquely.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- IF_Valid  in  1  fetch presents a valid instruction this cycle.
- IF_Instr  in  32  fetched instruction word.
- IF_PC  in  32  PC of the fetched instruction.
- IF_ExceptType  in  EXC_W  fetch exception bits (e.g. address error, TLB refill).
- IF_PResult  in  PRED_W  prediction record for this instruction.
- Q_Full  out  1  queue holds DEPTH entries; fetch must hold its output and not advance PC.
- ID_Wr  in  1  ID register captures the head this cycle.
- ID_Flush  in  1  discard all entries.
- Q_Valid  out  1  head entry valid.
- Q_Instr  out  32  head instruction; 32'h0 (NOP) when empty.
- Q_PC  out  32  head PC; 0 when empty.
- Q_ExceptType  out  EXC_W  head exception bits; 0 when empty.
- Q_PResult  out  PRED_W  head prediction record; 0 when empty.
- Q_Count  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Circular buffer with write pointer wp, read pointer rp (each $clog2(DEPTH) bits, wrapping modulo DEPTH) and occupancy count cnt.
- Push = IF_Valid && !Q_Full && !ID_Flush. Writes entry[wp] and increments wp.
- Pop = ID_Wr && Q_Valid && !ID_Flush. Increments rp.
- cnt_next = cnt + Push − Pop. Push and pop in the same cycle leave cnt unchanged.
- Q_Full = (cnt == DEPTH), combinational from registered cnt. There is no same-cycle bypass: when full, a push is rejected even if a pop occurs in the same cycle. Fetch retries next cycle.
- Q_Valid = (cnt != 0). Q_Instr, Q_PC, Q_ExceptType and Q_PResult read entry[rp] combinationally, gated to zero when !Q_Valid. An empty queue therefore feeds ID a bubble.
- ID_Flush has highest priority:
  - rp, wp and cnt go to 0 next edge.
  - Any simultaneous push or pop is ignored.
  - Storage contents are not cleared; they are masked by Q_Valid.
- ID_Wr with an empty queue is not an error. No state changes, and ID captures zeros.
- Entries carrying nonzero exception bits are queued and popped like any other. The queue never interprets exception or prediction fields.
- Storage array has no reset. All pointer and count state resets asynchronously.

## Timing
- Reset (resetn low, async):
  - rp = wp = cnt = 0
  - Q_Valid = 0, Q_Full = 0, Q_Count = 0
  - all data outputs 0
- Latency: an instruction pushed at edge N is visible on the head outputs after edge N (one cycle minimum, fetch-to-ID-input). It is captured by ID at edge N+1 if ID_Wr=1.
- Throughput: one push and one pop per cycle in steady state when 0 < cnt < DEPTH.
- Q_Full and Q_Valid depend only on registered state, so there is no combinational path from IF_Valid or ID_Wr to either.
- Flush: takes effect at the next edge. In the following cycle Q_Valid=0, and fetch may push the redirected target in that same cycle.
- Reset deasserted mid-stream: the queue starts empty. Upstream must re-present any instruction it had not seen accepted.

## Test plan
- Reset then 4 pushes (PC 0x1000, 0x1004, 0x1008, 0x100C) with ID_Wr=0. Expect:
  - Q_Count 1, 2, 3, 4
  - Q_Full=1 after the 4th push
  - a 5th push (PC 0x1010) is rejected, and Q_PC stays 0x1000
- Full queue, ID_Wr=1 and IF_Valid=1 in the same cycle. Expect Q_PC to become 0x1004, Q_Count=3, the push rejected, and PC 0x1010 accepted the next cycle.
- Steady state, IF_Valid=1 and ID_Wr=1 for 20 cycles, PCs incrementing by 4. Expect:
  - Q_PC sequence in order with no gaps
  - Q_Count constant at 1
  - pointers wrap past DEPTH with no corruption
- 3 entries held, ID_Flush=1 together with IF_Valid=1 (PC 0x2000). Expect Q_Valid=0, Q_Count=0 and the push dropped. In the next cycle, a push of 0xBFC00380 appears at the head.
- Empty queue with ID_Wr=1. Expect Q_Valid=0 and Q_Instr/Q_PC/Q_ExceptType/Q_PResult all 0, with count unchanged. Entry with IF_ExceptType=8'h04: expect it returned unchanged at the head.
- Assert resetn low asynchronously mid-cycle with 2 entries queued. Expect Q_Valid=0 and Q_Count=0 immediately, without waiting for a clock edge.
